// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle datapath: sequences fetch, decode, execute,
// memory and write-back steps, stalls on mem_ready and latches an illegal-opcode flag.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_WB_MEM = 4'd6,
        S_MEM_WR = 4'd7,
        S_JUMP   = 4'd8
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_R   = 3'b010;
    localparam logic [2:0] ALU_J   = 3'b011;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        illegal_d  = illegal_q;
        alu_op     = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_source  = 2'b00;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR load and PC+4 commit only in the cycle memory delivers.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                if (opcode == OP_RTYPE)                     state_d = S_EXEC_R;
                else if (opcode == OP_LW || opcode == OP_SW) state_d = S_ADDR;
                else if (opcode == OP_J)                    state_d = S_JUMP;
                else begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_R;
                state_d   = S_WB_R;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW)      state_d = S_MEM_RD;
                else if (opcode == OP_SW) state_d = S_MEM_WR;
                else                      state_d = S_FETCH;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = mem_ready ? S_WB_MEM : S_MEM_RD;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_d   = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                alu_op    = ALU_J;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset dominates: no strobe may reach memory or state elements while rst is high.
        if (rst) begin
            alu_op     = 3'b000;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_source  = 2'b00;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            iord       = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
        end
    end

    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: instruction-level reference model feeds an
// expected-output queue that a per-cycle monitor drains and compares.
module tb_multicycle_control;

    localparam logic [5:0] OP_R  = 6'b000000;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_J  = 6'b000010;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] aop;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] ps;
        logic       pcw, irw, mrd, mwr, rw, iord, rdst, m2r, ill;
    } obs_t;

    logic       clk, rst, mem_ready;
    logic [5:0] opcode;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write;
    logic       iord, reg_dst, mem_to_reg, illegal;
    logic [3:0] state;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_source(pc_source), .pc_write(pc_write), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .iord(iord), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   ill_m  = 1'b0;

    // Expected outputs of one cycle, straight from the per-state output table.
    function automatic obs_t exp_out(input int st, input bit mr, input bit r, input bit ill);
        obs_t o;
        o     = '0;
        o.st  = st[3:0];
        o.ill = ill;
        if (!r) begin
            case (st)
                0: begin o.mrd = 1; o.sb = 2'b01; o.irw = mr; o.pcw = mr; end
                2: begin o.sa = 1; o.aop = 3'b010; end
                3: begin o.rw = 1; o.rdst = 1; end
                4: begin o.sa = 1; o.sb = 2'b10; end
                5: begin o.mrd = 1; o.iord = 1; end
                6: begin o.rw = 1; o.m2r = 1; end
                7: begin o.mwr = 1; o.iord = 1; end
                8: begin o.pcw = 1; o.ps = 2'b10; o.aop = 3'b011; end
                default: ;
            endcase
        end
        return o;
    endfunction

    always @(negedge clk) begin
        obs_t a, e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{state, alu_op, alu_src_a, alu_src_b, pc_source, pc_write, ir_write,
                  mem_read, mem_write, reg_write, iord, reg_dst, mem_to_reg, illegal};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs @%0d: got st=%0d vec=%h, expected st=%0d vec=%h",
                         cyc, a.st, a, e.st, e);
            end
        end
    end

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst = 1'b1; mem_ready = 1'b1; opcode = 6'($urandom);
            exp_q.push_back(exp_out(0, 1'b1, 1'b1, ill_m));
            ill_m = 1'b0;
        end
    endtask

    // One instruction as a walk over its state path; fw/mw are wait cycles in
    // FETCH and in the memory state; rst_at is the cycle index to reset on (-1 = none).
    task automatic do_instr(input logic [5:0] op, input int fw, input int mw, input int rst_at);
        int  path[$];
        int  n;
        int  waits;
        bit  mr;
        bit  legal;
        n = 0;
        path = '{0, 1};
        legal = 1'b1;
        if (op == OP_R)       begin path.push_back(2); path.push_back(3); end
        else if (op == OP_LW) begin path.push_back(4); path.push_back(5); path.push_back(6); end
        else if (op == OP_SW) begin path.push_back(4); path.push_back(7); end
        else if (op == OP_J)  path.push_back(8);
        else                  legal = 1'b0;
        foreach (path[i]) begin
            waits = (path[i] == 0) ? fw : ((path[i] == 5 || path[i] == 7) ? mw : 0);
            for (int w = 0; w <= waits; w++) begin
                if (path[i] == 0 || path[i] == 5 || path[i] == 7) mr = (w == waits);
                else mr = 1'($urandom);
                @(posedge clk); #1;
                mem_ready = mr;
                opcode    = (path[i] == 0) ? 6'($urandom) : op;
                if (n == rst_at) begin
                    rst = 1'b1;
                    exp_q.push_back(exp_out(path[i], mr, 1'b1, ill_m));
                    ill_m = 1'b0;
                    return;
                end
                rst = 1'b0;
                exp_q.push_back(exp_out(path[i], mr, 1'b0, ill_m));
                if (path[i] == 1 && !legal) ill_m = 1'b1;
                n++;
            end
        end
    endtask

    initial begin
        logic [5:0] op;
        int         k;
        rst = 1'b1; mem_ready = 1'b0; opcode = 6'd0;
        @(posedge clk); #1;

        do_reset(2);
        do_instr(OP_R,  0, 0, -1);
        do_instr(OP_LW, 0, 2, -1);
        do_instr(OP_SW, 0, 0, -1);
        do_instr(OP_SW, 1, 1, 4);      // reset lands in MEM_WR with mem_ready low
        do_instr(OP_J,  0, 0, -1);
        do_instr(6'b111111, 0, 0, -1);
        do_instr(OP_R,  1, 0, -1);     // illegal flag must persist across a legal op
        do_instr(OP_LW, 2, 0, -1);
        do_reset(1);
        do_instr(OP_R,  0, 0, -1);

        for (int i = 0; i < 120; i++) begin
            k = $urandom_range(0, 4);
            case (k)
                0: op = OP_R;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_J;
                default: begin
                    op = 6'($urandom);
                    if (op == OP_R || op == OP_LW || op == OP_SW || op == OP_J) op = 6'b111111;
                end
            endcase
            do_instr(op, $urandom_range(0, 2), $urandom_range(0, 3),
                     ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1);
            if ($urandom_range(0, 19) == 0) do_reset(1);
        end

        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected records left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
